// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flush controller for the 5-stage MIPS datapath.
// Detects load-use and mult/div (HI/LO) hazards, applies branch/jump
// redirect flushes, tracks the mult/div busy window and keeps saturating
// stall/flush performance counters.
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_muldiv_i,
    input  logic             id_reads_hilo_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_redirect_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             muldiv_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int MD_W = $clog2(MULDIV_CYCLES);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_CYCLES - 1);

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [MD_W-1:0] md_cnt;
    logic [MD_W-1:0] md_cnt_nxt;

    logic load_use;
    logic md_hazard;
    logic stall;
    logic md_issue;

    // Hazard terms; $0 as a load destination never creates a dependency.
    always_comb begin
        load_use  = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
        md_hazard = (state == MD_BUSY) && (id_muldiv_i || id_reads_hilo_i);
        stall     = !ex_redirect_i && (load_use || md_hazard);
        md_issue  = (state == RUN) && id_muldiv_i && !stall && !ex_redirect_i;
    end

    // FSM state and busy down-counter register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Next-state logic: issue loads the busy window, which then counts down
    // regardless of redirects (the mult/div is older than the branch).
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            RUN: begin
                if (md_issue) begin
                    state_nxt  = MD_BUSY;
                    md_cnt_nxt = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    md_cnt_nxt = md_cnt - MD_W'(1);
                end
            end
            default: begin
                state_nxt  = RUN;
                md_cnt_nxt = '0;
            end
        endcase
    end

    // Pipeline control outputs: redirect beats stall beats normal flow.
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        if (ex_redirect_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (stall) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end
    end

    // Busy flag comes straight from the registered state.
    always_comb begin
        muldiv_busy_o = (state == MD_BUSY);
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!pc_write_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (ex_redirect_i && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic compared against a behavioural reference model.
module tb_hazard_ctrl;

    localparam int MDC    = 4;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk_i;
    logic          rst_n;
    logic [4:0]    id_rs_i;
    logic [4:0]    id_rt_i;
    logic          id_uses_rt_i;
    logic          id_muldiv_i;
    logic          id_reads_hilo_i;
    logic          ex_memread_i;
    logic [4:0]    ex_rt_i;
    logic          ex_redirect_i;
    logic          pc_write_o;
    logic          ifid_write_o;
    logic          ifid_flush_o;
    logic          idex_flush_o;
    logic          muldiv_busy_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    int checks;
    int errors;

    // Reference model: cycles of busy window left, and counter values.
    int busy_left;
    int m_stall;
    int m_flush;

    hazard_ctrl #(
        .MULDIV_CYCLES(MDC),
        .CNT_W        (CW)
    ) dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_uses_rt_i   (id_uses_rt_i),
        .id_muldiv_i    (id_muldiv_i),
        .id_reads_hilo_i(id_reads_hilo_i),
        .ex_memread_i   (ex_memread_i),
        .ex_rt_i        (ex_rt_i),
        .ex_redirect_i  (ex_redirect_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_flush_o   (idex_flush_o),
        .muldiv_busy_o  (muldiv_busy_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs_i         = 5'd0;
        id_rt_i         = 5'd0;
        id_uses_rt_i    = 1'b0;
        id_muldiv_i     = 1'b0;
        id_reads_hilo_i = 1'b0;
        ex_memread_i    = 1'b0;
        ex_rt_i         = 5'd0;
        ex_redirect_i   = 1'b0;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(muldiv_busy_o), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
        busy_left = 0;
        m_stall   = 0;
        m_flush   = 0;
        @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    // One clock: check combinational outputs, apply the edge, check state.
    task automatic cycle();
        bit lu, mh, st, red, issue;
        bit e_pc, e_ifw, e_iff, e_idf;
        #2;
        red = ex_redirect_i;
        lu  = ex_memread_i && (ex_rt_i != 0) &&
              ((ex_rt_i == id_rs_i) || (id_uses_rt_i && ex_rt_i == id_rt_i));
        mh  = (busy_left > 0) && (id_muldiv_i || id_reads_hilo_i);
        st  = !red && (lu || mh);
        e_pc  = !st;
        e_ifw = !st;
        e_iff = red;
        e_idf = red || st;
        chk("pc_write", 32'(pc_write_o), 32'(e_pc));
        chk("ifid_write", 32'(ifid_write_o), 32'(e_ifw));
        chk("ifid_flush", 32'(ifid_flush_o), 32'(e_iff));
        chk("idex_flush", 32'(idex_flush_o), 32'(e_idf));
        issue = (busy_left == 0) && id_muldiv_i && !st && !red;
        @(posedge clk_i);
        if (issue) busy_left = MDC;
        else if (busy_left > 0) busy_left--;
        if (st && m_stall < CNTMAX) m_stall++;
        if (red && m_flush < CNTMAX) m_flush++;
        #1;
        chk("muldiv_busy", 32'(muldiv_busy_o), 32'(busy_left > 0));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt_o), 32'(m_flush));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        busy_left = 0;
        m_stall = 0;
        m_flush = 0;
        clear_inputs();

        // Reset state and idle flow.
        do_reset();
        #1;
        chk("idle_pc_write", 32'(pc_write_o), 32'd1);
        chk("idle_ifid_write", 32'(ifid_write_o), 32'd1);
        chk("idle_ifid_flush", 32'(ifid_flush_o), 32'd0);
        chk("idle_idex_flush", 32'(idex_flush_o), 32'd0);
        cycle();

        // Load-use on rs: one bubble, then flow resumes.
        ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8;
        cycle();
        ex_memread_i = 1'b0;
        cycle();
        chk("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);

        // Load to $0 and unused rt never stall.
        ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0;
        cycle();
        ex_rt_i = 5'd9; id_rt_i = 5'd9; id_rs_i = 5'd3; id_uses_rt_i = 1'b0;
        cycle();
        id_uses_rt_i = 1'b1;
        cycle();
        clear_inputs();

        // Mult/div busy window with mfhi waiting in ID.
        do_reset();
        id_muldiv_i = 1'b1;
        cycle();
        chk("md_busy_after_issue", 32'(muldiv_busy_o), 32'd1);
        id_muldiv_i = 1'b0; id_reads_hilo_i = 1'b1;
        for (int unsigned i = 0; i < MDC; i++) cycle();
        chk("md_busy_end", 32'(muldiv_busy_o), 32'd0);
        chk("md_stall_cnt", 32'(stall_cnt_o), 32'd4);
        cycle();
        clear_inputs();

        // Back-to-back mult/div: second one waits out the whole window.
        id_muldiv_i = 1'b1;
        for (int unsigned i = 0; i < MDC + 2; i++) cycle();
        clear_inputs();

        // Redirect together with load-use.
        do_reset();
        ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5; ex_redirect_i = 1'b1;
        cycle();
        chk("red_flush_cnt", 32'(flush_cnt_o), 32'd1);
        chk("red_stall_cnt", 32'(stall_cnt_o), 32'd0);
        clear_inputs();

        // Redirect together with would-be issue: no issue.
        id_muldiv_i = 1'b1; ex_redirect_i = 1'b1;
        cycle();
        chk("red_no_issue", 32'(muldiv_busy_o), 32'd0);
        clear_inputs();

        // Reset two cycles into the busy window, then a clean issue.
        id_muldiv_i = 1'b1;
        cycle();
        id_muldiv_i = 1'b0;
        cycle();
        cycle();
        do_reset();
        id_muldiv_i = 1'b1;
        cycle();
        chk("post_rst_issue", 32'(muldiv_busy_o), 32'd1);
        clear_inputs();

        // Counter saturation under a held stall.
        do_reset();
        ex_memread_i = 1'b1; ex_rt_i = 5'd7; id_rt_i = 5'd7; id_uses_rt_i = 1'b1;
        for (int unsigned i = 0; i < 20; i++) cycle();
        chk("sat_stall_cnt", 32'(stall_cnt_o), 32'd15);
        clear_inputs();

        // Randomized traffic against the reference model.
        do_reset();
        for (int unsigned i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            id_rs_i         = 5'($urandom_range(0, 3));
            id_rt_i         = 5'($urandom_range(0, 3));
            ex_rt_i         = 5'($urandom_range(0, 3));
            id_uses_rt_i    = 1'($urandom_range(0, 1));
            ex_memread_i    = 1'($urandom_range(0, 1));
            id_muldiv_i     = ($urandom_range(0, 9) < 3);
            id_reads_hilo_i = ($urandom_range(0, 9) < 3);
            ex_redirect_i   = ($urandom_range(0, 19) < 3);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the 5-stage MIPS datapath. It watches the instruction in ID and the instruction already latched in the ID/EX register, then drives PC write-enable, IF/ID write-enable, IF/ID flush and the ID/EX flush. The ID/EX flush output connects to the ID/EX register's flush input. The block also tracks the multi-cycle mult/div unit's busy window with a small FSM and keeps saturating stall and flush performance counters.

## Interface
- MULDIV_CYCLES, 32, cycles the mult/div unit is busy after issue; must be >= 2
- CNT_W, 32, width of each performance counter
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_rs_i  in  5  rs field of the instruction in ID
- id_rt_i  in  5  rt field of the instruction in ID
- id_uses_rt_i  in  1  instruction in ID reads rt as a source
- id_muldiv_i  in  1  instruction in ID is mult/multu/div/divu
- id_reads_hilo_i  in  1  instruction in ID is mfhi/mflo
- ex_memread_i  in  1  ID/EX instruction is a load
- ex_rt_i  in  5  destination rt of the ID/EX instruction
- ex_redirect_i  in  1  branch taken or jump resolved in EX this cycle
- pc_write_o  out  1  PC register load enable
- ifid_write_o  out  1  IF/ID register load enable
- ifid_flush_o  out  1  zero the IF/ID register at the next edge
- idex_flush_o  out  1  zero the ID/EX register at the next edge (bubble)
- muldiv_busy_o  out  1  mult/div unit busy
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0
- flush_cnt_o  out  CNT_W  cycles with ex_redirect_i=1

## Operation
- FSM has two states: RUN and MD_BUSY. There is a down-counter md_cnt with width $clog2(MULDIV_CYCLES).
- Condition terms:
  - load_use = ex_memread_i & (ex_rt_i!=0) & ((ex_rt_i==id_rs_i) | (id_uses_rt_i & ex_rt_i==id_rt_i))
  - md_hazard = (state==MD_BUSY) & (id_muldiv_i | id_reads_hilo_i)
  - stall = ~ex_redirect_i & (load_use | md_hazard)
- Priority is redirect first, then stall, then normal flow:
  - ex_redirect_i=1: ifid_flush_o=1, idex_flush_o=1, pc_write_o=1, ifid_write_o=1. This overrides any load_use or md_hazard.
  - stall=1: pc_write_o=0, ifid_write_o=0, idex_flush_o=1, ifid_flush_o=0.
  - Otherwise: pc_write_o=1, ifid_write_o=1, both flushes 0.
- Mult/div issue condition: state==RUN & id_muldiv_i & ~stall & ~ex_redirect_i.
  - On the next edge: state goes to MD_BUSY and md_cnt loads MULDIV_CYCLES-1.
- In MD_BUSY:
  - md_cnt decrements every cycle.
  - At the edge where md_cnt==0, state returns to RUN.
  - Redirects do not affect md_cnt, because the issuing mult/div is older than the branch.
- muldiv_busy_o = (state==MD_BUSY).
- A mult/div in ID during the final MD_BUSY cycle (md_cnt==0) is still stalled. It issues in the following cycle, when the FSM is in RUN.
- Counters:
  - stall_cnt_o increments on every edge where pc_write_o==0.
  - flush_cnt_o increments on every edge where ex_redirect_i==1.
  - Both saturate at all-ones and never wrap.
- Register $0 never causes a load-use hazard.

## Timing
- All control outputs (pc_write, ifid_write, ifid_flush, idex_flush) are combinational from the inputs plus registered state, so they are valid in the same cycle as the inputs.
- muldiv_busy_o and both counters are registered; they have no combinational input path.
- Reset values:
  - Internal state: state=RUN, md_cnt=0, stall_cnt_o=0, flush_cnt_o=0, muldiv_busy_o=0.
  - With all inputs 0: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_flush_o=0.
- An asserted rst_n mid-operation immediately aborts MD_BUSY and clears the counters. The first edge after deassertion behaves as RUN.
- A load-use hazard costs exactly 1 bubble. On the next cycle the load has left ID/EX, so load_use drops without any stored state.
- Mult/div busy window: the issue edge plus MULDIV_CYCLES cycles of muldiv_busy_o=1.
- Simultaneous events:
  - Redirect and load_use together: redirect wins; stall_cnt is not incremented.
  - Issue and redirect together: no issue; the state stays RUN.

## Test plan
- Load-use: ex_memread_i=1, ex_rt_i=8, id_rs_i=8.
  - Required: pc_write_o=0, ifid_write_o=0, idex_flush_o=1 for exactly 1 cycle; then ex_memread_i=0 and flow resumes; stall_cnt_o=1.
- Load to $0: ex_rt_i=0, id_rs_i=0, ex_memread_i=1.
  - Required: no stall; pc_write_o=1.
  - Also: id_uses_rt_i=0 with ex_rt_i==id_rt_i=9 gives no stall.
- Mult/div, MULDIV_CYCLES=4: issue with id_muldiv_i=1 at edge N.
  - Required: muldiv_busy_o=1 for edges N..N+3 and 0 after.
  - mfhi held in ID from N stalls for 4 cycles; stall_cnt_o=4.
- Redirect during load_use: ex_redirect_i=1 and load_use=1 together.
  - Required: ifid_flush_o=1, idex_flush_o=1, pc_write_o=1; flush_cnt_o increments by 1; stall_cnt_o unchanged.
- Reset mid-MD_BUSY: pull rst_n low 2 cycles after issue.
  - Required: muldiv_busy_o=0 and both counters 0 immediately (asynchronous); the next mult/div issues without stall.
- Saturation, CNT_W=4: hold a stall for 20 cycles.
  - Required: stall_cnt_o sticks at 15.
